tmds_channel_encoder: RTL and testbench

TMDS_CHANNEL_ENCODER -- requirements
Module: tmds_channel_encoder

---
 rtl/tmds_channel_encoder_pkg.sv | 31 +++
 rtl/tmds_channel_encoder_popcount8.sv | 12 +
 rtl/tmds_channel_encoder.sv | 122 ++++++++++++
 tb/tb_tmds_channel_encoder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/tmds_channel_encoder_pkg.sv
// Shared TMDS constants: control symbols, HDMI TERC4 table, disparity width.
// Consumed by tmds_channel_encoder (TERC4 table used only with TMDS_ENC_TERC4_EN).
package tmds_pkg;

    localparam int DISP_W = 6;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // Index 15 first: packed concatenation fills from the MSB entry down.
    localparam logic [15:0][9:0] TERC4_TBL = {
        10'b1011000011, 10'b0101100011, 10'b1001110001, 10'b1010001110,
        10'b1011000110, 10'b0110011100, 10'b0100111001, 10'b1011001100,
        10'b0100111100, 10'b0110001110, 10'b0100011110, 10'b0101110001,
        10'b1011100010, 10'b1011100100, 10'b1001100011, 10'b1010011100
    };

    function automatic logic [9:0] ctrl_sym(input logic [1:0] cd);
        logic [9:0] s;
        case (cd)
            2'b00:   s = CTRL_00;
            2'b01:   s = CTRL_01;
            2'b10:   s = CTRL_10;
            default: s = CTRL_11;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tmds_channel_encoder_popcount8.sv
// Combinational ones counter for one byte.
module tmds_popcount8 (
    input  logic [7:0] i_d,
    output logic [3:0] o_n
);

    always_comb begin
        o_n = '0;
        for (int i = 0; i < 8; i++) o_n = o_n + {3'b000, i_d[i]};
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// Two-stage DVI/HDMI TMDS channel encoder: one 10-bit symbol per pixel clock.
// Optional HDMI data-island TERC4 coding is compiled in with TMDS_ENC_TERC4_EN.
module tmds_channel_encoder
    import tmds_pkg::*;
#(
    parameter bit BLANK_CLR_DISP = 1'b1
) (
    input  logic       clock_pixel,
    input  logic       reset_n,
    input  logic [7:0] iVD,
    input  logic [1:0] iCD,
    input  logic       iVDE,
`ifdef TMDS_ENC_TERC4_EN
    input  logic       iADE,
    input  logic [3:0] iAD,
`endif
    output logic [9:0] oTMDS
);

    logic [3:0] w_n1d, w_n1q, w_n0q;
    logic       w_use_xnor;
    logic [8:0] w_qm;
    logic [7:0] w_qm_n;

    tmds_popcount8 u_pc_vd (.i_d(iVD),        .o_n(w_n1d));
    tmds_popcount8 u_pc_q1 (.i_d(w_qm[7:0]),  .o_n(w_n1q));
    tmds_popcount8 u_pc_q0 (.i_d(w_qm_n),     .o_n(w_n0q));

    assign w_use_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !iVD[0]);
    assign w_qm_n     = ~w_qm[7:0];

    // Transition-minimising chain; q_m[8] records which chain was used.
    always_comb begin
        w_qm    = '0;
        w_qm[0] = iVD[0];
        for (int i = 1; i < 8; i++)
            w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ iVD[i]) : (w_qm[i-1] ^ iVD[i]);
        w_qm[8] = ~w_use_xnor;
    end

    logic [8:0] r_qm;
    logic [3:0] r_n1q, r_n0q;
    logic [1:0] r_cd;
    logic       r_vde;
`ifdef TMDS_ENC_TERC4_EN
    logic       r_ade;
    logic [3:0] r_ad;
`endif

    always_ff @(posedge clock_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_qm  <= '0;
            r_n1q <= '0;
            r_n0q <= '0;
            r_cd  <= '0;
            r_vde <= 1'b0;
`ifdef TMDS_ENC_TERC4_EN
            r_ade <= 1'b0;
            r_ad  <= '0;
`endif
        end else begin
            r_qm  <= w_qm;
            r_n1q <= w_n1q;
            r_n0q <= w_n0q;
            r_cd  <= iCD;
            r_vde <= iVDE;
`ifdef TMDS_ENC_TERC4_EN
            r_ade <= iADE;
            r_ad  <= iAD;
`endif
        end
    end

    logic signed [DISP_W-1:0] r_cnt, w_cnt_nxt;
    logic signed [DISP_W-1:0] w_n1s, w_n0s, w_diff, w_qm8x2, w_nqm8x2;
    logic                     w_cnt_pos, w_cnt_neg;
    logic [9:0]               r_tmds, w_sym;

    assign w_n1s     = $signed({{(DISP_W-4){1'b0}}, r_n1q});
    assign w_n0s     = $signed({{(DISP_W-4){1'b0}}, r_n0q});
    assign w_diff    = w_n1s - w_n0s;
    assign w_qm8x2   = $signed({{(DISP_W-2){1'b0}}, r_qm[8], 1'b0});
    assign w_nqm8x2  = $signed({{(DISP_W-2){1'b0}}, ~r_qm[8], 1'b0});
    assign w_cnt_neg = r_cnt[DISP_W-1];
    assign w_cnt_pos = !r_cnt[DISP_W-1] && (r_cnt != '0);

    always_comb begin
        w_sym     = ctrl_sym(r_cd);
        w_cnt_nxt = BLANK_CLR_DISP ? '0 : r_cnt;
        if (r_vde) begin
            if ((r_cnt == '0) || (r_n1q == r_n0q)) begin
                w_sym     = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                w_cnt_nxt = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
            end else if ((w_cnt_pos && (r_n1q > r_n0q)) || (w_cnt_neg && (r_n0q > r_n1q))) begin
                w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
                w_cnt_nxt = r_cnt + w_qm8x2 - w_diff;
            end else begin
                w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
                w_cnt_nxt = r_cnt + w_diff - w_nqm8x2;
            end
        end
`ifdef TMDS_ENC_TERC4_EN
        else if (r_ade) begin
            w_sym     = TERC4_TBL[r_ad];
            w_cnt_nxt = '0;
        end
`endif
    end

    always_ff @(posedge clock_pixel or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_tmds <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_tmds <= w_sym;
        end
    end

    assign oTMDS = r_tmds;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Directed bench: two encoders (blanking clears / holds disparity) on shared inputs.
module tb_tmds_channel_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    logic [9:0] o_clr, o_hold;
`ifdef TMDS_ENC_TERC4_EN
    logic       ade = 1'b0;
    logic [3:0] ad  = 4'h0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tmds_channel_encoder dut_clr (
        .clock_pixel(clk), .reset_n(rst_n), .iVD(vd), .iCD(cd), .iVDE(vde),
`ifdef TMDS_ENC_TERC4_EN
        .iADE(ade), .iAD(ad),
`endif
        .oTMDS(o_clr)
    );

    tmds_channel_encoder #(.BLANK_CLR_DISP(1'b0)) dut_hold (
        .clock_pixel(clk), .reset_n(rst_n), .iVD(vd), .iCD(cd), .iVDE(vde),
`ifdef TMDS_ENC_TERC4_EN
        .iADE(ade), .iAD(ad),
`endif
        .oTMDS(o_hold)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; vde = 1'b1; vd = 8'hA5; cd = 2'b11;
        tick(); tick(); tick();
        chk("reset_clr", o_clr, 10'h000);
        chk("reset_hold", o_hold, 10'h000);

        rst_n = 1'b1; vde = 1'b0; cd = 2'b00;
        tick(); tick();
        chk("post_rst_ctrl_clr", o_clr, 10'h354);
        chk("post_rst_ctrl_hold", o_hold, 10'h354);

        // Three zero bytes from cnt=0: -8, +2, -6
        vde = 1'b1; vd = 8'h00;
        tick(); tick();
        chk("zero1", o_clr, 10'h100);
        tick();
        chk("zero2", o_clr, 10'h3FF);
        vde = 1'b0; cd = 2'b00;
        tick();
        chk("zero3_clr", o_clr, 10'h100);
        chk("zero3_hold", o_hold, 10'h100);
        vde = 1'b1; vd = 8'hFF;
        tick();
        chk("blank_clr", o_clr, 10'h354);
        chk("blank_hold", o_hold, 10'h354);
        tick();
        chk("ff1_clr", o_clr, 10'h200);
        chk("ff1_hold", o_hold, 10'h0FF);
        vde = 1'b0; cd = 2'b01;
        tick();
        chk("ff2_clr", o_clr, 10'h0FF);
        chk("ff2_hold", o_hold, 10'h200);
        cd = 2'b10;
        tick();
        chk("ctrl01", o_clr, 10'h0AB);
        cd = 2'b11;
        tick();
        chk("ctrl10", o_clr, 10'h154);
        cd = 2'b00;
        tick();
        chk("ctrl11", o_clr, 10'h2AB);
        tick();
        chk("ctrl00", o_hold, 10'h354);

        // Reset mid-line: in-flight AA must not appear
        vde = 1'b1; vd = 8'hAA;
        tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst", o_clr, 10'h000);
        tick();
        chk("rst_hold_low", o_hold, 10'h000);
        rst_n = 1'b1; vd = 8'h55;
        tick();
        chk("inflight_discard", o_clr, 10'h354);
        vd = 8'hAA;
        tick();
        chk("byte55", o_clr, 10'h133);
        vd = 8'h00;
        tick();
        chk("byteAA", o_hold, 10'h233);
        vde = 1'b0; cd = 2'b00;
        tick();
        chk("gap_pre_clr", o_clr, 10'h100);
        chk("gap_pre_hold", o_hold, 10'h100);
        vde = 1'b1; vd = 8'h00;
        tick();
        chk("gap_ctrl", o_clr, 10'h354);
        vde = 1'b0;
        tick();
        chk("gap_post_clr", o_clr, 10'h100);
        chk("gap_post_hold", o_hold, 10'h3FF);

`ifdef TMDS_ENC_TERC4_EN
        ade = 1'b1; ad = 4'h0;
        tick(); tick();
        chk("terc4_0", o_clr, 10'h29C);
        vde = 1'b1; vd = 8'h00;
        tick(); tick();
        chk("vde_over_ade", o_hold, 10'h100);
        ade = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
